// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: tracks fetched branch predictions, resolves them in Execute, updates the BHT and flushes on mispredict.
// Define BRU_STATS_EN to build the saturating branch/mispredict statistics counters.
module branch_resolve_unit #(
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        brF1,
    input  logic        brF2,
    input  logic [10:0] pcF1,
    input  logic [10:0] pcF2,
    input  logic        predF1,
    input  logic        predF2,
    input  logic        brE1,
    input  logic        brE2,
    input  logic [10:0] pcE1,
    input  logic [10:0] pcE2,
    input  logic        takenE1,
    input  logic        takenE2,
    input  logic [10:0] targetE1,
    input  logic [10:0] targetE2,
    output logic        upd_branch1,
    output logic        upd_branch2,
    output logic        upd_taken1,
    output logic        upd_taken2,
    output logic [10:0] upd_pc1,
    output logic [10:0] upd_pc2,
    output logic        fetch_stall,
    output logic        flush,
    output logic [10:0] redirect_pc,
    output logic        pc_mismatch,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [2:0]    fc_q, fc_d;
    logic [11:0]   mem_q [DEPTH];
    logic [11:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd_branch1_q, upd_branch1_d, upd_branch2_q, upd_branch2_d;
    logic          upd_taken1_q, upd_taken1_d, upd_taken2_q, upd_taken2_d;
    logic [10:0]   upd_pc1_q, upd_pc1_d, upd_pc2_q, upd_pc2_d;
    logic [10:0]   redirect_pc_q, redirect_pc_d;
    logic          pc_mismatch_q, pc_mismatch_d;

    logic          idle, push1, push2, v1, v2, has1, has2, pop1, pop2, mis1, mis2, bad1, bad2;
    logic [11:0]   ent1, ent2;

    assign idle        = state_q == IDLE;
    assign fetch_stall = cnt_q > CW'(DEPTH - 2);
    assign push1       = idle && !fetch_stall && brF1;
    assign push2       = idle && !fetch_stall && brF2;

    // An empty FIFO reads as a not-taken prediction and flags a PC mismatch.
    assign v1   = idle && brE1;
    assign has1 = cnt_q != '0;
    assign ent1 = mem_q[rd_q];
    assign pop1 = v1 && has1;
    assign mis1 = v1 && ((has1 && ent1[0]) != takenE1);
    assign bad1 = v1 && (!has1 || ent1[11:1] != pcE1);

    // Slot 2 is wrong-path once slot 1 mispredicts.
    assign v2   = idle && brE2 && !mis1;
    assign has2 = cnt_q > CW'(pop1);
    assign ent2 = mem_q[rd_q + PW'(pop1)];
    assign pop2 = v2 && has2;
    assign mis2 = v2 && ((has2 && ent2[0]) != takenE2);
    assign bad2 = v2 && (!has2 || ent2[11:1] != pcE2);

    always_comb begin
        state_d       = state_q;
        fc_d          = fc_q;
        mem_d         = mem_q;
        wr_d          = wr_q + PW'(push1) + PW'(push2);
        rd_d          = rd_q + PW'(pop1) + PW'(pop2);
        cnt_d         = cnt_q + CW'(push1) + CW'(push2) - CW'(pop1) - CW'(pop2);
        redirect_pc_d = redirect_pc_q;
        upd_branch1_d = v1;
        upd_branch2_d = v2;
        upd_taken1_d  = v1 && takenE1;
        upd_taken2_d  = v2 && takenE2;
        upd_pc1_d     = v1 ? pcE1 : 11'd0;
        upd_pc2_d     = v2 ? pcE2 : 11'd0;
        pc_mismatch_d = pc_mismatch_q | bad1 | bad2;
        if (push1) mem_d[wr_q] = {pcF1, predF1};
        if (push2) mem_d[wr_q + PW'(push1)] = {pcF2, predF2};
        if (idle && (mis1 || mis2)) begin
            state_d       = FLUSH;
            fc_d          = 3'(FLUSH_CYCLES - 1);
            wr_d          = '0;
            rd_d          = '0;
            cnt_d         = '0;
            redirect_pc_d = mis1 ? (takenE1 ? targetE1 : pcE1 + 11'd1)
                                 : (takenE2 ? targetE2 : pcE2 + 11'd1);
        end else if (!idle) begin
            fc_d = fc_q - 3'd1;
            if (fc_q == '0) begin
                state_d       = IDLE;
                redirect_pc_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fc_q          <= '0;
            mem_q         <= '{default: '0};
            wr_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
            upd_branch1_q <= 1'b0;
            upd_branch2_q <= 1'b0;
            upd_taken1_q  <= 1'b0;
            upd_taken2_q  <= 1'b0;
            upd_pc1_q     <= '0;
            upd_pc2_q     <= '0;
            pc_mismatch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fc_q          <= fc_d;
            mem_q         <= mem_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
            upd_branch1_q <= upd_branch1_d;
            upd_branch2_q <= upd_branch2_d;
            upd_taken1_q  <= upd_taken1_d;
            upd_taken2_q  <= upd_taken2_d;
            upd_pc1_q     <= upd_pc1_d;
            upd_pc2_q     <= upd_pc2_d;
            pc_mismatch_q <= pc_mismatch_d;
        end
    end

    assign flush       = state_q == FLUSH;
    assign redirect_pc = redirect_pc_q;
    assign upd_branch1 = upd_branch1_q;
    assign upd_branch2 = upd_branch2_q;
    assign upd_taken1  = upd_taken1_q;
    assign upd_taken2  = upd_taken2_q;
    assign upd_pc1     = upd_pc1_q;
    assign upd_pc2     = upd_pc2_q;
    assign pc_mismatch = pc_mismatch_q;

`ifdef BRU_STATS_EN
    logic [15:0] stat_branches_q, stat_branches_d, stat_mispredicts_q, stat_mispredicts_d;
    logic [16:0] br_sum, mp_sum;

    always_comb begin
        br_sum             = {1'b0, stat_branches_q} + 17'(v1) + 17'(v2);
        mp_sum             = {1'b0, stat_mispredicts_q} + 17'(mis1 || mis2);
        stat_branches_d    = br_sum[16] ? 16'hFFFF : br_sum[15:0];
        stat_mispredicts_d = mp_sum[16] ? 16'hFFFF : mp_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench; a queue-based reference model predicts each cycle's registered outputs.
module tb_branch_resolve_unit;
    localparam int DEPTH = 8;
    localparam int FC    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        brF1, brF2, predF1, predF2, brE1, brE2, takenE1, takenE2;
    logic [10:0] pcF1, pcF2, pcE1, pcE2, targetE1, targetE2;
    logic        upd_branch1, upd_branch2, upd_taken1, upd_taken2, fetch_stall, flush, pc_mismatch;
    logic [10:0] upd_pc1, upd_pc2, redirect_pc;
    logic [15:0] stat_branches, stat_mispredicts;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        ub1, ub2, ut1, ut2;
        logic [10:0] up1, up2, rpc;
        logic        fl, st, mm;
        logic [15:0] sb, sm;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] mq[$];
    int          m_fl, m_sb, m_sm;
    logic [10:0] m_rpc;
    logic        m_mm;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .brF1(brF1), .brF2(brF2), .pcF1(pcF1), .pcF2(pcF2), .predF1(predF1), .predF2(predF2),
        .brE1(brE1), .brE2(brE2), .pcE1(pcE1), .pcE2(pcE2), .takenE1(takenE1), .takenE2(takenE2),
        .targetE1(targetE1), .targetE2(targetE2),
        .upd_branch1(upd_branch1), .upd_branch2(upd_branch2), .upd_taken1(upd_taken1), .upd_taken2(upd_taken2),
        .upd_pc1(upd_pc1), .upd_pc2(upd_pc2), .fetch_stall(fetch_stall), .flush(flush),
        .redirect_pc(redirect_pc), .pc_mismatch(pc_mismatch),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clr();
        brF1 = 0; brF2 = 0; predF1 = 0; predF2 = 0; pcF1 = 0; pcF2 = 0;
        brE1 = 0; brE2 = 0; takenE1 = 0; takenE2 = 0; pcE1 = 0; pcE2 = 0; targetE1 = 0; targetE2 = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_fl = 0; m_sb = 0; m_sm = 0; m_rpc = 0; m_mm = 0;
    endtask

    task automatic model();
        exp_t        e;
        logic        idle, stall, mis, p;
        logic [11:0] ent;
        logic [10:0] r;
        e     = '0;
        idle  = m_fl == 0;
        stall = mq.size() > DEPTH - 2;
        mis   = 0;
        r     = 0;
        if (idle && brE1) begin
            if (mq.size() > 0) begin
                ent = mq.pop_front();
                p   = ent[0];
                if (ent[11:1] != pcE1) m_mm = 1;
            end else begin
                p    = 0;
                m_mm = 1;
            end
            e.ub1 = 1; e.ut1 = takenE1; e.up1 = pcE1; m_sb++;
            if (p != takenE1) begin mis = 1; r = takenE1 ? targetE1 : pcE1 + 11'd1; end
        end
        if (idle && brE2 && !mis) begin
            if (mq.size() > 0) begin
                ent = mq.pop_front();
                p   = ent[0];
                if (ent[11:1] != pcE2) m_mm = 1;
            end else begin
                p    = 0;
                m_mm = 1;
            end
            e.ub2 = 1; e.ut2 = takenE2; e.up2 = pcE2; m_sb++;
            if (p != takenE2) begin mis = 1; r = takenE2 ? targetE2 : pcE2 + 11'd1; end
        end
        if (idle && !stall) begin
            if (brF1) mq.push_back({pcF1, predF1});
            if (brF2) mq.push_back({pcF2, predF2});
        end
        if (mis) begin
            mq.delete();
            m_fl  = FC;
            m_rpc = r;
            m_sm++;
        end else if (!idle) begin
            m_fl--;
        end
        e.fl  = m_fl > 0;
        e.rpc = m_fl > 0 ? m_rpc : 11'd0;
        e.st  = mq.size() > DEPTH - 2;
        e.mm  = m_mm;
`ifdef BRU_STATS_EN
        e.sb = m_sb > 65535 ? 16'hFFFF : 16'(m_sb);
        e.sm = m_sm > 65535 ? 16'hFFFF : 16'(m_sm);
`endif
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("upd_branch1", upd_branch1, e.ub1);
            check("upd_branch2", upd_branch2, e.ub2);
            if (e.ub1) begin
                check("upd_taken1", upd_taken1, e.ut1);
                check("upd_pc1", upd_pc1, e.up1);
            end
            if (e.ub2) begin
                check("upd_taken2", upd_taken2, e.ut2);
                check("upd_pc2", upd_pc2, e.up2);
            end
            check("flush", flush, e.fl);
            check("redirect_pc", redirect_pc, e.rpc);
            check("fetch_stall", fetch_stall, e.st);
            check("pc_mismatch", pc_mismatch, e.mm);
            check("stat_branches", stat_branches, e.sb);
            check("stat_mispredicts", stat_mispredicts, e.sm);
        end
    endtask

    initial begin
        clr();
        model_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect_pc, 0);
        check("rst_stall", fetch_stall, 0);
        check("rst_upd_branch1", upd_branch1, 0);
        check("rst_pc_mismatch", pc_mismatch, 0);
        reset = 1;

        // correct taken prediction
        brF1 = 1; pcF1 = 11'h010; predF1 = 1; step();
        clr(); brE1 = 1; pcE1 = 11'h010; takenE1 = 1; step();
        clr(); step();

        // not-taken prediction resolved taken; FLUSH ignores Execute/fetch; FIFO emptied
        clr(); brF1 = 1; pcF1 = 11'h030; predF1 = 0; brF2 = 1; pcF2 = 11'h031; predF2 = 1; step();
        clr(); brE1 = 1; pcE1 = 11'h030; takenE1 = 1; targetE1 = 11'h123; step();
        clr(); brE1 = 1; pcE1 = 11'h555; takenE1 = 1; targetE1 = 11'h7AA; brF1 = 1; pcF1 = 11'h600; predF1 = 1; step();
        clr(); step();
        clr(); brF1 = 1; pcF1 = 11'h040; predF1 = 1; step();
        clr(); brE1 = 1; pcE1 = 11'h040; takenE1 = 1; step();

        // slot 1 mispredicts not-taken at 0x7FF: redirect wraps, slot 2 squashed
        clr(); brF1 = 1; pcF1 = 11'h7FF; predF1 = 1; brF2 = 1; pcF2 = 11'h100; predF2 = 1; step();
        clr(); brE1 = 1; pcE1 = 11'h7FF; takenE1 = 0; targetE1 = 11'h333;
        brE2 = 1; pcE2 = 11'h100; takenE2 = 1; targetE2 = 11'h444; step();
        clr(); repeat (2) step();

        // fill to stall, ignored pushes, pop to unstall, simultaneous push/pop, drain
        for (int i = 0; i < 6; i++) begin
            clr(); brF1 = 1; pcF1 = 11'(32'h200 + 2 * i); brF2 = 1; pcF2 = 11'(32'h201 + 2 * i); step();
        end
        for (int i = 0; i < 2; i++) begin
            clr(); brE1 = 1; pcE1 = 11'(32'h200 + i); step();
        end
        clr(); brF1 = 1; pcF1 = 11'h208; brF2 = 1; pcF2 = 11'h209;
        brE1 = 1; pcE1 = 11'h202; brE2 = 1; pcE2 = 11'h203; step();
        for (int i = 0; i < 3; i++) begin
            clr(); brE1 = 1; pcE1 = 11'(32'h204 + 2 * i); brE2 = 1; pcE2 = 11'(32'h205 + 2 * i); step();
        end

        // head PC differs from Execute PC: sticky mismatch
        clr(); brF1 = 1; pcF1 = 11'h021; predF1 = 0; step();
        clr(); brE1 = 1; pcE1 = 11'h020; takenE1 = 0; step();
        clr(); repeat (2) step();

        // asynchronous reset in the middle of FLUSH
        clr(); brF1 = 1; pcF1 = 11'h050; predF1 = 1; step();
        clr(); brE1 = 1; pcE1 = 11'h050; takenE1 = 0; step();
        clr();
        #2 reset = 0;
        #1;
        check("arst_flush", flush, 0);
        check("arst_redirect", redirect_pc, 0);
        check("arst_stall", fetch_stall, 0);
        check("arst_pc_mismatch", pc_mismatch, 0);
        check("arst_stat_branches", stat_branches, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1;
        brF1 = 1; pcF1 = 11'h060; predF1 = 1; step();
        clr(); brE1 = 1; pcE1 = 11'h060; takenE1 = 1; targetE1 = 11'h070; step();
        clr(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
